// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared widths and arbiter state encoding for the sdram front end
package sdram_pkg;

    localparam int SDRAM_ADDR_W  = 24;
    localparam int SDRAM_DATA_W  = 16;
    localparam int SDRAM_BURST_W = 9;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-client round-robin arbiter in front of sdram_controller
//
// Ports:
//   clk, res                 sdram_clock and synchronous active-high reset
//   cN_req/wr/addr/burst     client N request (level, held until cN_ack)
//   cN_data_in               client N write data, muxed onto mem_data_in while it owns the bus
//   cN_ack                   client N completion pulse (mem_ack pass-through or watchdog abort)
//   data_out                 controller read data, broadcast to both clients
//   timeout                  sticky per-client watchdog abort flags
//   mem_*                    single request interface to sdram_controller
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 13
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     c0_req,
    input  logic                     c0_wr,
    input  logic [SDRAM_ADDR_W-1:0]  c0_addr,
    input  logic [SDRAM_BURST_W-1:0] c0_burst,
    input  logic [SDRAM_DATA_W-1:0]  c0_data_in,
    output logic                     c0_ack,
    input  logic                     c1_req,
    input  logic                     c1_wr,
    input  logic [SDRAM_ADDR_W-1:0]  c1_addr,
    input  logic [SDRAM_BURST_W-1:0] c1_burst,
    input  logic [SDRAM_DATA_W-1:0]  c1_data_in,
    output logic                     c1_ack,
    output logic [SDRAM_DATA_W-1:0]  data_out,
    output logic [1:0]               timeout,
    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [SDRAM_ADDR_W-1:0]  mem_addr,
    output logic [SDRAM_BURST_W-1:0] mem_burst,
    output logic [SDRAM_DATA_W-1:0]  mem_data_in,
    input  logic [SDRAM_DATA_W-1:0]  mem_data_out,
    input  logic                     mem_ack
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e               state_q, state_d;
    logic                     owner_q, owner_d;
    logic                     last_q, last_d;
    logic                     mem_req_q, mem_req_d;
    logic                     mem_wr_q, mem_wr_d;
    logic [SDRAM_ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [SDRAM_BURST_W-1:0] mem_burst_q, mem_burst_d;
    logic [1:0]               timeout_q, timeout_d;
    logic [CNT_W-1:0]         wdog_q, wdog_d;
    // Registered ack for a watchdog abort; owner_q is still valid during GAP.
    logic                     to_ack_q, to_ack_d;

    logic                     pick;
    logic                     done_ack;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= ARB_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_burst_q <= '0;
            timeout_q   <= 2'b00;
            wdog_q      <= '0;
            to_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_burst_q <= mem_burst_d;
            timeout_q   <= timeout_d;
            wdog_q      <= wdog_d;
            to_ack_q    <= to_ack_d;
        end
    end

    // On a tie the port that did not own the bus last time wins.
    always_comb begin
        pick = 1'b0;
        if (c0_req && c1_req) begin
            pick = ~last_q;
        end else if (c1_req) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_burst_d = mem_burst_q;
        timeout_d   = timeout_q;
        wdog_d      = wdog_q;
        to_ack_d    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (c0_req || c1_req) begin
                    owner_d     = pick;
                    mem_wr_d    = pick ? c1_wr    : c0_wr;
                    mem_addr_d  = pick ? c1_addr  : c0_addr;
                    mem_burst_d = pick ? c1_burst : c0_burst;
                    mem_req_d   = 1'b1;
                    wdog_d      = '0;
                    state_d     = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                wdog_d = wdog_q + CNT_W'(1);
                // A real ack beats a watchdog expiry landing on the same cycle.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    last_d    = owner_q;
                    state_d   = ARB_GAP;
                end else if (wdog_q == WDOG_LAST) begin
                    mem_req_d          = 1'b0;
                    timeout_d[owner_q] = 1'b1;
                    to_ack_d           = 1'b1;
                    last_d             = owner_q;
                    state_d            = ARB_GAP;
                end
            end
            ARB_GAP: begin
                // Owner's req is still high here; ignoring it forces req low for a cycle.
                state_d = ARB_IDLE;
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign done_ack = ((state_q == ARB_BUSY) && mem_ack) || to_ack_q;

    assign c0_ack      = done_ack && !owner_q;
    assign c1_ack      = done_ack &&  owner_q;
    assign mem_data_in = owner_q ? c1_data_in : c0_data_in;
    assign data_out    = mem_data_out;
    assign timeout     = timeout_q;
    assign mem_req     = mem_req_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_burst   = mem_burst_q;

endmodule
